// File: rtl/enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Mode selectors and a cheap multi-hot test.
package enc_pkg;

    localparam int ENC_ONEHOT = 0;
    localparam int ENC_PRIO   = 1;
    localparam int ENC_RR     = 2;

    // Widest request vector the encoder supports.
    localparam int ENC_MAX_N  = 256;

    // True when more than one bit is set: clearing the lowest
    // set bit leaves something behind only for multi-hot input.
    function automatic logic multi_hot(
        input logic [ENC_MAX_N-1:0] v
    );
        logic [ENC_MAX_N-1:0] rest;
        rest = v & (v - ENC_MAX_N'(1));
        return rest != '0;
    endfunction

endpackage

// File: rtl/enc_rr_pick.sv
// Round-robin pick: first set bit at or above ptr,
// wrapping back to bit 0 when nothing is set above it.
module enc_rr_pick
    import enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [N-1:0]     upper;
    logic [IDX_W-1:0] up_idx;
    logic [IDX_W-1:0] any_idx;
    logic             up_found;
    logic             any_found;

    // Keep only requests at or above the pointer.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = vec[i] && (i >= int'(ptr));
        end
    end

    // Lowest set bit of both the masked and the full vector;
    // scanning downward lets the lowest hit win.
    always_comb begin
        up_idx    = '0;
        up_found  = 1'b0;
        any_idx   = '0;
        any_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (upper[i]) begin
                up_idx   = IDX_W'(i);
                up_found = 1'b1;
            end
            if (vec[i]) begin
                any_idx   = IDX_W'(i);
                any_found = 1'b1;
            end
        end
    end

    // Prefer the search from ptr upward, else wrap around.
    always_comb begin
        idx   = up_found ? up_idx : any_idx;
        found = any_found;
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// N-to-log2(N) encoder with one registered output stage,
// valid/ready on both sides and a multi-hot error counter.
module prio_encoder_pipe
    import enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_hit,
    output logic             out_multi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    logic             accept;
    logic             vec_any;
    logic             vec_multi;
    logic [IDX_W-1:0] pr_idx;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_hit;
    logic             cnt_inc;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign vec_any  = in_vec != '0;
    assign vec_multi = multi_hot(ENC_MAX_N'(in_vec));

    // Highest set bit; also the position of a lone one-hot bit.
    always_comb begin
        pr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (in_vec[i]) begin
                pr_idx = IDX_W'(i);
            end
        end
    end

    if (MODE == ENC_RR) begin : g_rr
        logic [IDX_W-1:0] ptr;

        enc_rr_pick #(
            .N     (N),
            .IDX_W (IDX_W)
        ) u_pick (
            .vec   (in_vec),
            .ptr   (ptr),
            .idx   (rr_idx),
            .found (rr_found)
        );

        // Advance past the winner; zero vectors leave ptr alone.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr <= '0;
            end else if (accept && nxt_hit) begin
                if (nxt_idx == IDX_W'(N - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= nxt_idx + IDX_W'(1);
                end
            end
        end
    end else begin : g_no_rr
        assign rr_idx   = '0;
        assign rr_found = 1'b0;
    end

    // Apply the encoding rule chosen at elaboration.
    always_comb begin
        nxt_idx = '0;
        nxt_hit = 1'b0;
        unique case (1'b1)
            (MODE == ENC_PRIO): begin
                nxt_hit = vec_any;
                nxt_idx = pr_idx;
            end
            (MODE == ENC_RR): begin
                nxt_hit = rr_found;
                nxt_idx = rr_idx;
            end
            default: begin
                nxt_hit = vec_any && !vec_multi;
                nxt_idx = nxt_hit ? pr_idx : '0;
            end
        endcase
    end

    // Output stage: load on accept, drain once taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_hit   <= 1'b0;
            out_multi <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= nxt_idx;
            out_hit   <= nxt_hit;
            out_multi <= vec_multi;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign cnt_inc = accept
                  && (MODE == ENC_ONEHOT)
                  && vec_multi
                  && (err_cnt != '1);

    // Saturating multi-hot counter; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (cnt_inc) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Self-checking bench: four encoder variants driven in lockstep,
// directed tables plus random traffic against a reference model.
module tb_prio_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;

    logic       rdy   [4];
    logic [2:0] idx   [4];
    logic       hit   [4];
    logic       multi [4];
    logic       vld   [4];
    logic [7:0] cnt0;
    logic [1:0] cnts;
    logic [7:0] cnt2;
    logic [7:0] cnt3;

    int errors = 0;
    int checks = 0;

    // Instance k: 0 one-hot, 1 one-hot with 2-bit counter,
    // 2 fixed priority, 3 round-robin.
    int modes [4] = '{0, 0, 1, 2};
    int cmax  [4] = '{255, 3, 255, 255};

    bit m_valid;
    int m_idx   [4];
    bit m_hit   [4];
    bit m_multi [4];
    int m_cnt   [4];
    int m_ptr;

    always #5 clk = ~clk;

    prio_encoder_pipe #(.N(8), .MODE(0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec),
        .in_valid(in_valid), .in_ready(rdy[0]),
        .out_idx(idx[0]), .out_hit(hit[0]),
        .out_multi(multi[0]), .out_valid(vld[0]),
        .out_ready(out_ready), .err_cnt(cnt0),
        .err_clr(err_clr)
    );

    prio_encoder_pipe #(.N(8), .MODE(0), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec),
        .in_valid(in_valid), .in_ready(rdy[1]),
        .out_idx(idx[1]), .out_hit(hit[1]),
        .out_multi(multi[1]), .out_valid(vld[1]),
        .out_ready(out_ready), .err_cnt(cnts),
        .err_clr(err_clr)
    );

    prio_encoder_pipe #(.N(8), .MODE(1), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec),
        .in_valid(in_valid), .in_ready(rdy[2]),
        .out_idx(idx[2]), .out_hit(hit[2]),
        .out_multi(multi[2]), .out_valid(vld[2]),
        .out_ready(out_ready), .err_cnt(cnt2),
        .err_clr(err_clr)
    );

    prio_encoder_pipe #(.N(8), .MODE(2), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec),
        .in_valid(in_valid), .in_ready(rdy[3]),
        .out_idx(idx[3]), .out_hit(hit[3]),
        .out_multi(multi[3]), .out_valid(vld[3]),
        .out_ready(out_ready), .err_cnt(cnt3),
        .err_clr(err_clr)
    );

    typedef struct {
        logic [7:0] v;
        int         idx;
        bit         hit;
        bit         multi;
    } vec_t;

    vec_t tab [12];

    task automatic chk(input string nm, input int k,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s u%0d: got %0d want %0d",
                     nm, k, act, exp);
        end
    endtask

    function automatic int get_cnt(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnts);
            2:       return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    function automatic int popc(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // Encoding rules straight from their definitions.
    function automatic void enc(input int mode, input logic [7:0] v,
                                input int ptr,
                                output int ix, output bit h);
        ix = 0;
        h  = 0;
        if (mode == 0) begin
            if (popc(v) == 1) begin
                h  = 1;
                ix = $clog2(int'(v));
            end
        end else if (mode == 1) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    ix = i;
                    h  = 1;
                    break;
                end
            end
        end else begin
            for (int s = 0; s < 8; s++) begin
                if (v[(ptr + s) % 8]) begin
                    ix = (ptr + s) % 8;
                    h  = 1;
                    break;
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_ptr   = 0;
        for (int k = 0; k < 4; k++) begin
            m_idx[k] = 0; m_hit[k] = 0;
            m_multi[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] v, input bit iv,
                              input bit ordy, input bit clr);
        bit acc;
        int ix;
        bit h;
        acc = iv && (!m_valid || ordy);
        for (int k = 0; k < 4; k++) begin
            if (acc) begin
                enc(modes[k], v, m_ptr, ix, h);
                m_idx[k]   = ix;
                m_hit[k]   = h;
                m_multi[k] = popc(v) > 1;
            end
            if (clr) m_cnt[k] = 0;
            else if (acc && modes[k] == 0 && popc(v) > 1
                     && m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
        if (acc && m_hit[3]) m_ptr = (m_idx[3] + 1) % 8;
        if (acc) m_valid = 1;
        else if (ordy) m_valid = 0;
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", k, int'(vld[k]), int'(m_valid));
            chk("out_idx", k, int'(idx[k]), m_idx[k]);
            chk("out_hit", k, int'(hit[k]), int'(m_hit[k]));
            chk("out_multi", k, int'(multi[k]), int'(m_multi[k]));
            chk("err_cnt", k, get_cnt(k), m_cnt[k]);
        end
    endtask

    task automatic cycle(input logic [7:0] v, input bit iv,
                         input bit ordy, input bit clr);
        in_vec = v; in_valid = iv; out_ready = ordy; err_clr = clr;
        #1;
        for (int k = 0; k < 4; k++)
            chk("in_ready", k, int'(rdy[k]),
                int'(!m_valid || ordy));
        model_step(v, iv, ordy, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset away from the clock edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int k = 0; k < 4; k++)
            chk("rst_in_ready", k, int'(rdy[k]), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_exp [6];
        bit rr_hit [6];
        logic [7:0] rv;

        tab[0]  = '{8'h01, 0, 1, 0};
        tab[1]  = '{8'h02, 1, 1, 0};
        tab[2]  = '{8'h04, 2, 1, 0};
        tab[3]  = '{8'h08, 3, 1, 0};
        tab[4]  = '{8'h10, 4, 1, 0};
        tab[5]  = '{8'h20, 5, 1, 0};
        tab[6]  = '{8'h40, 6, 1, 0};
        tab[7]  = '{8'h80, 7, 1, 0};
        tab[8]  = '{8'h03, 0, 0, 1};
        tab[9]  = '{8'h28, 0, 0, 1};
        tab[10] = '{8'hFF, 0, 0, 1};
        tab[11] = '{8'h00, 0, 0, 0};
        rr_exp = '{0, 2, 7, 0, 0, 2};
        rr_hit = '{1, 1, 1, 1, 0, 1};

        in_vec = '0; in_valid = 0; out_ready = 1; err_clr = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        for (int k = 0; k < 4; k++)
            chk("init_in_ready", k, int'(rdy[k]), 1);
        rst_n = 1'b1;

        // One-hot walk, then illegal and zero vectors.
        for (int i = 0; i < 12; i++) begin
            cycle(tab[i].v, 1, 1, 0);
            chk("tab_idx", 0, int'(idx[0]), tab[i].idx);
            chk("tab_hit", 0, int'(hit[0]), int'(tab[i].hit));
            chk("tab_multi", 0, int'(multi[0]), int'(tab[i].multi));
            chk("tab_valid", 0, int'(vld[0]), 1);
            if (i == 9) begin
                chk("prio_idx", 2, int'(idx[2]), 5);
                chk("prio_hit", 2, int'(hit[2]), 1);
                chk("prio_multi", 2, int'(multi[2]), 1);
                chk("prio_cnt", 2, int'(cnt2), 0);
            end
            if (i == 11) begin
                chk("prio_zero_hit", 2, int'(hit[2]), 0);
                chk("prio_zero_idx", 2, int'(idx[2]), 0);
            end
        end
        chk("cnt_after3", 0, int'(cnt0), 3);
        chk("cnt_sat3", 1, int'(cnts), 3);

        // Clear, then saturate the narrow counter.
        cycle(8'h00, 0, 1, 1);
        chk("cnt_clr", 0, int'(cnt0), 0);
        cycle(8'hFF, 1, 1, 1);
        chk("clr_wins", 0, int'(cnt0), 0);
        repeat (5) cycle(8'hFF, 1, 1, 0);
        chk("cnt_five", 0, int'(cnt0), 5);
        chk("cnt_sat", 1, int'(cnts), 3);

        // Backpressure holds the result and stalls input.
        cycle(8'h04, 1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            cycle(8'h10, 1, 0, 0);
            chk("bp_in_ready", 0, int'(rdy[0]), 0);
            chk("bp_idx", 0, int'(idx[0]), 2);
        end
        cycle(8'h10, 1, 1, 0);
        chk("bp_release", 0, int'(idx[0]), 4);

        // Reset drops a held result mid-stream.
        chk("pre_rst_valid", 0, int'(vld[0]), 1);
        async_reset();

        // Round-robin walk with wrap and a zero vector.
        for (int i = 0; i < 6; i++) begin
            cycle((i == 4) ? 8'h00 : 8'h85, 1, 1, 0);
            chk("rr_idx", 3, int'(idx[3]), rr_exp[i]);
            chk("rr_hit", 3, int'(hit[3]), int'(rr_hit[i]));
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       rv = 8'(1 << $urandom_range(0, 7));
                1:       rv = 8'h00;
                default: rv = 8'($urandom);
            endcase
            cycle(rv, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
            if (n == 300) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
